// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, default
// geometry and a counter-width helper.
package digit_serial_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter needs at least one bit even when a single digit spans the word.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_adder_digit.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into its top bit so the
// caller can form signed overflow on the most significant digit.
module adder_digit
  import digit_serial_adder_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    // NOTE: every output and temporary gets a value before the loop so no
    // path through the block leaves one unassigned (which would infer a latch).
    s    = '0;
    cmsb = cin;
    c    = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: operands are captured on start, then processed
// DIGIT bits per clock from the least significant digit upward.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state, state_nxt;
  logic   load, step, last;

  logic [NDIG-1:0][DIGIT-1:0] op_a, op_b;
  logic                       carry;
  logic [CW-1:0]              cnt;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] res_nxt;

  assign last = (cnt == LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  adder_digit #(.DIGIT(DIGIT)) u_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_cout),
    .cmsb (dig_cmsb)
  );

  generate
    if (NDIG == 1) begin : g_single
      assign dig_a   = op_a[0];
      assign dig_b   = op_b[0];
      assign res_nxt = dig_s;
    end else begin : g_multi
      // Finished digits enter at the top and drift down; after NDIG steps the
      // first digit sits in the least significant position.
      logic [WIDTH-DIGIT-1:0] res_q;

      assign dig_a   = op_a[cnt];
      assign dig_b   = op_b[cnt];
      assign res_nxt = {dig_s, res_q};

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       res_q <= '0;
        else if (step) res_q <= res_nxt[WIDTH-1:DIGIT];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand registers are cleared as well, so nothing undefined
      // reaches the adder before the first capture.
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (step) begin
      carry <= dig_cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        s    <= res_nxt;
        cout <= dig_cout;
        ovf  <= dig_cmsb ^ dig_cout;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboarded bench: four geometries share one stimulus stream; each has its
// own arithmetic reference model, expectation queue and output monitor.
module tb_digit_serial_adder;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    longint      t0;
  } exp_t;

  function automatic int cfg_width(input int g);
    case (g)
      0: return 16;
      1: return 16;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_digit(input int g);
    case (g)
      0: return 4;
      1: return 16;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  // Plain integer arithmetic: unsigned result/carry and exact signed range test.
  function automatic exp_t ref_model(input int w, input logic [31:0] a_in,
                                     input logic [31:0] b_in, input logic sub_in,
                                     input logic cin_in, input longint t0);
    exp_t   e;
    longint mask, half, ua, ub, sa, sb, r, exact;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a_in) & mask;
    ub    = longint'(b_in) & mask;
    sa    = (ua >= half) ? ua - (mask + 1) : ua;
    sb    = (ub >= half) ? ub - (mask + 1) : ub;
    if (sub_in) begin
      r      = ua - ub;
      e.cout = (ua >= ub);
      exact  = sa - sb;
    end else begin
      r      = ua + ub + longint'(cin_in);
      e.cout = ((r >> w) & 1) != 0;
      exact  = sa + sb + longint'(cin_in);
    end
    e.s   = 32'(r & mask);
    e.ovf = (exact > half - 1) || (exact < -half);
    e.t0  = t0;
    return e;
  endfunction

  logic        clk, rst, start, sub, cin;
  logic [31:0] a, b;

  logic [31:0] s_o    [4];
  logic        busy_o [4];
  logic        done_o [4];
  logic        cout_o [4];
  logic        ovf_o  [4];
  int          pending[4];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = cfg_width(g);
    localparam int D = cfg_digit(g);
    localparam int N = W / D;

    logic [W-1:0] s_w;
    logic         busy_w, done_w, cout_w, ovf_w;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .cin   (cin),
      .busy  (busy_w),
      .done  (done_w),
      .s     (s_w),
      .cout  (cout_w),
      .ovf   (ovf_w)
    );

    assign s_o[g]    = 32'(s_w);
    assign busy_o[g] = busy_w;
    assign done_o[g] = done_w;
    assign cout_o[g] = cout_w;
    assign ovf_o[g]  = ovf_w;

    exp_t q[$];
    int   left = 0;  // edges still owned by the operation in flight

    // Acceptance model: a start is taken only once the previous operation has
    // used up its N digit edges.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        left <= 0;
        q.delete();
      end else if (left > 0) begin
        left <= left - 1;
      end else if (start) begin
        left <= N;
        q.push_back(ref_model(W, a, b, sub, cin, $time));
      end
    end

    always @(negedge clk) begin
      pending[g] <= q.size();
      if (!rst) begin
        check($sformatf("c%0d_busy", g), 64'(busy_w), 64'(left > 0));
        if (done_w) begin
          if (q.size() == 0) begin
            check($sformatf("c%0d_spurious_done", g), 64'(1), 64'(0));
          end else begin
            check($sformatf("c%0d_sum", g), {31'd0, cout_w, 32'(s_w)},
                  {31'd0, q[0].cout, q[0].s});
            check($sformatf("c%0d_ovf", g), 64'(ovf_w), 64'(q[0].ovf));
            check($sformatf("c%0d_latency", g), 64'($time - q[0].t0),
                  64'(N * 10 + 5));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic scramble();
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s"},    64'(s_o[0]),    64'(0));
    check({tag, "_cout"}, 64'(cout_o[0]), 64'(0));
    check({tag, "_ovf"},  64'(ovf_o[0]),  64'(0));
    check({tag, "_busy"}, 64'(busy_o[0]), 64'(0));
    check({tag, "_done"}, 64'(done_o[0]), 64'(0));
  endtask

  // Directed op with fixed expectations for the 16/4 instance; the window is
  // long enough for every geometry to finish.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic subv, input logic cinv, input logic [15:0] es,
                        input logic ec, input logic eo);
    int          busy_cnt, done_cnt;
    logic [15:0] got_s;
    logic        got_c, got_o;
    busy_cnt = 0;
    done_cnt = 0;
    got_s    = '0;
    got_c    = 1'b0;
    got_o    = 1'b0;
    @(negedge clk);
    a = 32'(av); b = 32'(bv); sub = subv; cin = cinv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int i = 0; i < 10; i++) begin
      if (busy_o[0]) busy_cnt++;
      if (done_o[0]) begin
        done_cnt++;
        got_s = s_o[0][15:0];
        got_c = cout_o[0];
        got_o = ovf_o[0];
      end
      @(negedge clk);
      scramble();
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(4));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_s"},    64'(got_s), 64'(es));
    check({tag, "_cout"}, 64'(got_c), 64'(ec));
    check({tag, "_ovf"},  64'(got_o), 64'(eo));
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_op("add_9_3",     16'h0009, 16'h0003, 1'b0, 1'b1, 16'h000D, 1'b0, 1'b0);
    run_op("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_5_7",     16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // start held high: back-to-back operations, starts during RUN ignored
    @(negedge clk);
    dn = 0;
    scramble();
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o[0]) dn++;
      scramble();
    end
    start = 1'b0;
    check("b2b_done_count", 64'(dn), 64'(4));
    repeat (12) @(negedge clk);

    // reset in the second RUN cycle aborts the operation
    @(negedge clk);
    a = 32'h0000_1234; b = 32'h0000_0111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o[0]) dn++;
    end
    check("abort_no_done", 64'(dn), 64'(0));
    run_op("after_abort", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);

    // random regression across all geometries
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      scramble();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      repeat (8) begin
        @(negedge clk);
        scramble();
      end
    end

    repeat (12) @(negedge clk);
    for (int g = 0; g < 4; g++)
      check($sformatf("c%0d_pending_empty", g), 64'(pending[g]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
